// File: rtl/fsm_seq_monitor_if.sv
// -----------------------------------------------------------------------------
// fsm_seq_monitor_if
// Bundle between the upstream JK-flip-flop FSM (state code producer) and the
// sequence monitor that watches it.
//   Estado    : 2-bit state code from the upstream FSM
//   locked    : monitor is tracking a valid sequence
//   vueltas   : completed 4-state cycle count (CNT_W bits, wraps)
//   error     : sticky error flag
//   err_pulse : one-cycle pulse per detected error
//   err_cnt   : saturating error count (ERR_W bits)
//   seg       : active-low 7-segment digit {g,f,e,d,c,b,a} for vueltas[3:0]
// master : side that drives Estado and observes the monitor results
// slave  : the monitor itself
// -----------------------------------------------------------------------------
interface fsm_seq_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
);
  logic [1:0]       Estado;
  logic             locked;
  logic [CNT_W-1:0] vueltas;
  logic             error;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [6:0]       seg;

  modport master (
    output Estado,
    input  locked, vueltas, error, err_pulse, err_cnt, seg
  );

  modport slave (
    input  Estado,
    output locked, vueltas, error, err_pulse, err_cnt, seg
  );
endinterface

// File: rtl/fsm_seq_monitor.sv
// -----------------------------------------------------------------------------
// fsm_seq_monitor
// Watches the 2-bit state code of the upstream JK FSM, checks that it walks
// its 4-state cycle (binary or Gray order), counts completed cycles, flags
// illegal jumps and stalls, and drives a 7-segment digit with the count.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   mon : slave modport of fsm_seq_monitor_if (Estado in, results out)
// -----------------------------------------------------------------------------
module fsm_seq_monitor #(
  parameter bit GRAY      = 1'b0,
  parameter int CNT_W     = 8,
  parameter int ERR_W     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  fsm_seq_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  // Last code of the selected sequence; last -> 00 is the wrap that counts a lap.
  localparam logic [1:0] LAST_C      = GRAY ? 2'b10 : 2'b11;
  localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);
  localparam bit         STALL_EN    = (STALL_MAX != 0);

  // Successor of x in the selected sequence.
  function automatic logic [1:0] seq_next(input logic [1:0] x);
    logic [1:0] r;
    if (GRAY) begin
      case (x)
        2'b00:   r = 2'b01;
        2'b01:   r = 2'b11;
        2'b11:   r = 2'b10;
        2'b10:   r = 2'b00;
        default: r = 2'b00;
      endcase
    end else begin
      r = x + 2'b01;
    end
    return r;
  endfunction

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t           state_q;
  logic [1:0]       in_q;
  logic [1:0]       prev_q;
  logic [7:0]       stall_q;
  logic             locked_q;
  logic [CNT_W-1:0] vueltas_q;
  logic             error_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [6:0]       seg_q;

  logic [1:0]       nxt_s;
  logic             same_s;
  logic             step_s;
  logic             wrap_s;
  logic [7:0]       stall_inc_s;
  logic             stall_hit_s;
  logic             err_evt_s;

  // Classify the sampled code against the previous one.
  always_comb begin
    nxt_s       = seq_next(prev_q);
    same_s      = (in_q == prev_q);
    step_s      = (in_q == nxt_s);
    wrap_s      = step_s && (prev_q == LAST_C);
    // Saturate so a disabled stall check never wraps the counter.
    stall_inc_s = (stall_q == 8'hFF) ? stall_q : (stall_q + 8'd1);
    stall_hit_s = STALL_EN && same_s && (stall_inc_s == STALL_MAX_C);
    // A repeat and a jump are mutually exclusive, so one edge yields one event.
    if (state_q == ST_TRACK) begin
      err_evt_s = stall_hit_s || (!same_s && !step_s);
    end else begin
      err_evt_s = 1'b0;
    end
  end

  // Input pipeline, sequence FSM, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q        <= 2'b00;
      prev_q      <= 2'b00;
      stall_q     <= 8'd0;
      state_q     <= ST_SYNC;
      locked_q    <= 1'b0;
      vueltas_q   <= {CNT_W{1'b0}};
      error_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= {ERR_W{1'b0}};
      seg_q       <= 7'b1000000;
    end else begin
      in_q        <= mon.Estado;
      prev_q      <= in_q;
      // Digit follows the counter one edge later.
      seg_q       <= seg_decode(4'(vueltas_q));
      err_pulse_q <= err_evt_s;
      if (err_evt_s) begin
        error_q <= 1'b1;
        if (err_cnt_q != {ERR_W{1'b1}}) begin
          err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
      end
      case (state_q)
        ST_SYNC: begin
          stall_q <= 8'd0;
          if (in_q == 2'b00) begin
            state_q  <= ST_TRACK;
            locked_q <= 1'b1;
          end else begin
            locked_q <= 1'b0;
          end
        end
        ST_TRACK: begin
          if (err_evt_s) begin
            state_q  <= ST_ERR;
            locked_q <= 1'b0;
            stall_q  <= 8'd0;
          end else if (same_s) begin
            stall_q <= stall_inc_s;
          end else begin
            stall_q <= 8'd0;
            if (wrap_s) begin
              vueltas_q <= vueltas_q + CNT_W'(1);
            end
          end
        end
        ST_ERR: begin
          state_q  <= ST_SYNC;
          locked_q <= 1'b0;
          stall_q  <= 8'd0;
        end
        default: begin
          state_q  <= ST_SYNC;
          locked_q <= 1'b0;
          stall_q  <= 8'd0;
        end
      endcase
    end
  end

  assign mon.locked    = locked_q;
  assign mon.vueltas   = vueltas_q;
  assign mon.error     = error_q;
  assign mon.err_pulse = err_pulse_q;
  assign mon.err_cnt   = err_cnt_q;
  assign mon.seg       = seg_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_fsm_seq_monitor
// Directed bench for fsm_seq_monitor. Four instances share clk, rst and the
// Estado stimulus: binary/default, Gray, stall check disabled, and a narrow
// 4-bit count / 2-bit error count build. Each phase checks the instance it
// targets; expected values are hand-derived from the sequence rules.
// -----------------------------------------------------------------------------
module tb_fsm_seq_monitor;

  logic       clk;
  logic       rst;
  logic [1:0] estado;
  int         n_checks;
  int         n_errors;

  fsm_seq_monitor_if #(.CNT_W(8), .ERR_W(4)) if_bin();
  fsm_seq_monitor_if #(.CNT_W(8), .ERR_W(4)) if_gray();
  fsm_seq_monitor_if #(.CNT_W(8), .ERR_W(4)) if_nost();
  fsm_seq_monitor_if #(.CNT_W(4), .ERR_W(2)) if_small();

  assign if_bin.Estado   = estado;
  assign if_gray.Estado  = estado;
  assign if_nost.Estado  = estado;
  assign if_small.Estado = estado;

  fsm_seq_monitor #(.GRAY(1'b0)) dut_bin (
    .clk(clk), .rst(rst), .mon(if_bin)
  );
  fsm_seq_monitor #(.GRAY(1'b1)) dut_gray (
    .clk(clk), .rst(rst), .mon(if_gray)
  );
  fsm_seq_monitor #(.GRAY(1'b0), .STALL_MAX(0)) dut_nost (
    .clk(clk), .rst(rst), .mon(if_nost)
  );
  fsm_seq_monitor #(.GRAY(1'b0), .CNT_W(4), .ERR_W(2)) dut_small (
    .clk(clk), .rst(rst), .mon(if_small)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one code, let one rising edge sample it, settle 1 ns.
  task automatic step(input logic [1:0] v);
    estado = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input bit gray);
    for (int c = 0; c < n; c++) begin
      step(2'b01);
      step(gray ? 2'b11 : 2'b10);
      step(gray ? 2'b10 : 2'b11);
      step(2'b00);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    estado = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Directed stimulus and checks.
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    estado   = 2'b00;

    // Async reset: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_seg",     32'(if_bin.seg), 32'(7'b1000000));
    chk("rst_locked",  32'(if_bin.locked), 32'd0);
    chk("rst_vueltas", 32'(if_bin.vueltas), 32'd0);
    chk("rst_errcnt",  32'(if_bin.err_cnt), 32'd0);
    chk("rst_pulse",   32'(if_bin.err_pulse), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // in_q resets to 00, so the first edge after release locks.
    step(2'b00);
    chk("lock_after_rel", 32'(if_bin.locked), 32'd1);

    // Binary counting: 5 laps; the 5th wrap is decided one edge after its 00.
    run_cycles(5, 1'b0);
    chk("bin_vueltas_4", 32'(if_bin.vueltas), 32'd4);
    step(2'b01);
    chk("bin_vueltas_5", 32'(if_bin.vueltas), 32'd5);
    chk("bin_seg_lag",   32'(if_bin.seg), 32'(7'b0011001));
    step(2'b10);
    chk("bin_seg_5",     32'(if_bin.seg), 32'(7'b0010010));
    chk("bin_error",     32'(if_bin.error), 32'd0);
    chk("bin_errcnt",    32'(if_bin.err_cnt), 32'd0);
    chk("bin_locked",    32'(if_bin.locked), 32'd1);

    // Gray counting, then a binary-legal but Gray-illegal 01 -> 10 jump.
    do_reset();
    step(2'b00);
    run_cycles(3, 1'b1);
    step(2'b01);
    chk("gray_vueltas", 32'(if_gray.vueltas), 32'd3);
    chk("gray_noerr",   32'(if_gray.error), 32'd0);
    step(2'b10);
    chk("gray_pre_jump", 32'(if_gray.err_pulse), 32'd0);
    step(2'b10);
    chk("gray_pulse",   32'(if_gray.err_pulse), 32'd1);
    chk("gray_errcnt",  32'(if_gray.err_cnt), 32'd1);
    chk("gray_unlock",  32'(if_gray.locked), 32'd0);
    chk("gray_keepcnt", 32'(if_gray.vueltas), 32'd3);
    step(2'b10);
    chk("gray_pulse_1cyc", 32'(if_gray.err_pulse), 32'd0);
    chk("gray_sticky",     32'(if_gray.error), 32'd1);
    step(2'b00);
    chk("gray_sync_wait",  32'(if_gray.locked), 32'd0);
    step(2'b00);
    chk("gray_relock",     32'(if_gray.locked), 32'd1);

    // Stall: 01 held; 15th repeat is decided on the 17th edge of the hold.
    do_reset();
    step(2'b00);
    for (int n = 1; n <= 17; n++) begin
      step(2'b01);
      chk("stall_pulse", 32'(if_bin.err_pulse), 32'(n == 17));
    end
    step(2'b01);
    chk("stall_pulse_off", 32'(if_bin.err_pulse), 32'd0);
    chk("stall_sticky",    32'(if_bin.error), 32'd1);
    chk("stall_errcnt",    32'(if_bin.err_cnt), 32'd1);
    chk("stall_vueltas",   32'(if_bin.vueltas), 32'd0);
    repeat (300 - 18) step(2'b01);
    chk("nostall_error",  32'(if_nost.error), 32'd0);
    chk("nostall_errcnt", 32'(if_nost.err_cnt), 32'd0);
    chk("nostall_locked", 32'(if_nost.locked), 32'd1);
    chk("stall_still",    32'(if_bin.error), 32'd1);

    // Narrow build: count wrap and error-count saturation.
    do_reset();
    step(2'b00);
    run_cycles(17, 1'b0);
    chk("small_wrap_0", 32'(if_small.vueltas), 32'd0);
    step(2'b01);
    chk("small_wrap_1", 32'(if_small.vueltas), 32'd1);
    for (int e = 0; e < 5; e++) begin
      step(2'b11);
      step(2'b11);
      chk("small_jump_pulse", 32'(if_small.err_pulse), 32'd1);
      step(2'b00);
      step(2'b00);
      step(2'b01);
    end
    chk("small_errcnt_sat", 32'(if_small.err_cnt), 32'd3);
    chk("small_error",      32'(if_small.error), 32'd1);
    chk("small_vueltas",    32'(if_small.vueltas), 32'd1);
    chk("small_relocked",   32'(if_small.locked), 32'd1);

    // Reset in the middle of a lap discards the count.
    do_reset();
    step(2'b00);
    run_cycles(7, 1'b0);
    step(2'b01);
    step(2'b10);
    chk("mid_vueltas_7", 32'(if_bin.vueltas), 32'd7);
    chk("mid_seg_7",     32'(if_bin.seg), 32'(7'b1111000));
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_vueltas", 32'(if_bin.vueltas), 32'd0);
    chk("mid_rst_error",   32'(if_bin.error), 32'd0);
    chk("mid_rst_locked",  32'(if_bin.locked), 32'd0);
    chk("mid_rst_seg",     32'(if_bin.seg), 32'(7'b1000000));
    @(negedge clk);
    rst = 1'b0;
    step(2'b00);
    chk("mid_relock", 32'(if_bin.locked), 32'd1);
    step(2'b01);
    step(2'b10);
    step(2'b11);
    step(2'b00);
    chk("mid_no_wrap_yet", 32'(if_bin.vueltas), 32'd0);
    step(2'b01);
    chk("mid_fresh_wrap",  32'(if_bin.vueltas), 32'd1);
    chk("mid_error_clear", 32'(if_bin.error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
